// File: rtl/pixel_frame_buffer.sv
// Purpose : collects one IMG_W x IMG_H frame from a pixel-serial stream into a flat vector.
// Latency : frame_valid rises on the edge that accepts the last pixel of the frame.
// Backpr. : s_ready drops while a full frame waits for frame_ack, while en=0 and in reset.
//
// Ports:
//   clk, reset (sync, active-low), en (stage enable; 0 freezes all state)
//   s_valid / s_sof / s_data / s_ready : pixel stream in raster order
//   pixels      : flattened frame, pixel 0 in the most significant byte
//   frame_valid : pixels holds a complete frame; frame_ack releases it
//   pix_count   : pixels captured in the current frame
//   sof_err     : one-cycle pulse when a frame is restarted before completion
module pixel_frame_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  localparam int NPIX      = IMG_W * IMG_H,
  localparam int CW        = $clog2(NPIX + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       s_valid,
  input  logic                       s_sof,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       s_ready,
  output logic [DATA_WIDTH*NPIX-1:0] pixels,
  output logic                       frame_valid,
  input  logic                       frame_ack,
  output logic [CW-1:0]              pix_count,
  output logic                       sof_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [DATA_WIDTH*NPIX-1:0] pixels_q, pixels_d;
  logic [CW-1:0]              pix_count_q, pix_count_d;
  logic                       frame_valid_q, frame_valid_d;
  logic                       sof_err_q, sof_err_d;

  logic                       beat;
  logic                       wr_en;
  logic [CW-1:0]              wr_idx;

  // en and reset gate s_ready, so beat already implies en=1 and not in reset.
  assign s_ready = reset & en & (state_q != FULL);
  assign beat    = s_valid & s_ready;

  always_comb begin
    state_d       = state_q;
    pixels_d      = pixels_q;
    pix_count_d   = pix_count_q;
    frame_valid_d = frame_valid_q;
    sof_err_d     = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = '0;

    case (state_q)
      IDLE: begin
        // Beats without SOF are swallowed so the stream can resynchronise.
        if (beat && s_sof) begin
          wr_en       = 1'b1;
          pix_count_d = CW'(1);
          state_d     = FILL;
        end
      end
      FILL: begin
        if (beat) begin
          wr_en = 1'b1;
          if (s_sof) begin
            // Restart: stale bytes past index 0 are simply overwritten later.
            pix_count_d = CW'(1);
            sof_err_d   = 1'b1;
          end else begin
            wr_idx      = pix_count_q;
            pix_count_d = pix_count_q + CW'(1);
            if (pix_count_q == CW'(NPIX - 1)) begin
              state_d       = FULL;
              frame_valid_d = 1'b1;
            end
          end
        end
      end
      FULL: begin
        if (en && frame_ack) begin
          state_d       = IDLE;
          pix_count_d   = '0;
          frame_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pixel k lands in byte NPIX-1-k so that pixel 0 is the MS byte.
    if (wr_en) begin
      pixels_d[DATA_WIDTH*(NPIX-1-int'(wr_idx)) +: DATA_WIDTH] = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      pixels_q      <= '0;
      pix_count_q   <= '0;
      frame_valid_q <= 1'b0;
      sof_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pixels_q      <= pixels_d;
      pix_count_q   <= pix_count_d;
      frame_valid_q <= frame_valid_d;
      sof_err_q     <= sof_err_d;
    end
  end

  assign pixels      = pixels_q;
  assign pix_count   = pix_count_q;
  assign frame_valid = frame_valid_q;
  assign sof_err     = sof_err_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
module tb_pixel_frame_buffer;

  localparam int DW   = 8;
  localparam int NPIX = 784;
  localparam int CW   = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              s_valid;
  logic              s_sof;
  logic [DW-1:0]     s_data;
  logic              s_ready;
  logic [DW*NPIX-1:0] pixels;
  logic              frame_valid;
  logic              frame_ack;
  logic [CW-1:0]     pix_count;
  logic              sof_err;

  pixel_frame_buffer #(.DATA_WIDTH(8), .IMG_W(28), .IMG_H(28)) dut (
    .clk(clk), .reset(reset), .en(en), .s_valid(s_valid), .s_sof(s_sof),
    .s_data(s_data), .s_ready(s_ready), .pixels(pixels),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .pix_count(pix_count), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int sof_cnt = 0;
  bit chk_on = 1'b0;

  // Reference model: the frame is "the list of pixels received since the
  // last SOF"; its length is the capture count, and a full list means a
  // frame is on offer. img[] holds every byte ever written, so stale bytes
  // survive a restart exactly as they should.
  logic [7:0] img [NPIX];
  int         m_len = 0;
  bit         m_sof_err = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_len = 0;
      m_sof_err = 1'b0;
      for (int k = 0; k < NPIX; k++) img[k] = 8'h00;
    end else begin
      m_sof_err = 1'b0;
      if (s_valid && en && m_len != NPIX) begin
        if (s_sof) begin
          if (m_len > 0) m_sof_err = 1'b1;
          img[0] = s_data;
          m_len = 1;
        end else if (m_len > 0) begin
          img[m_len] = s_data;
          m_len++;
        end
      end else if (en && m_len == NPIX && frame_ack) begin
        m_len = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [DW*NPIX-1:0] exp_pix;
      for (int k = 0; k < NPIX; k++) exp_pix[8*(NPIX-1-k) +: 8] = img[k];
      check("s_ready", 32'(s_ready), 32'(reset && en && m_len != NPIX));
      check("frame_valid", 32'(frame_valid), 32'(m_len == NPIX));
      check("pix_count", 32'(pix_count), 32'(m_len));
      check("sof_err", 32'(sof_err), 32'(m_sof_err));
      n_chk++;
      if (pixels !== exp_pix) begin
        n_fail++;
        for (int k = 0; k < NPIX; k++) begin
          if (pixels[8*(NPIX-1-k) +: 8] !== exp_pix[8*(NPIX-1-k) +: 8]) begin
            $display("FAIL pixels byte %0d: got %0h expected %0h at %0t",
                     k, pixels[8*(NPIX-1-k) +: 8], exp_pix[8*(NPIX-1-k) +: 8], $time);
            break;
          end
        end
      end
      if (sof_err === 1'b1) sof_cnt++;
    end
  end

  // Offer one pixel, optionally after a random idle gap, and hold it until
  // it is accepted. Returns 1ns after the accepting edge.
  task automatic push(input logic [7:0] d, input logic sof, input int gap_max, input bit ack_noise);
    int  waited = 0;
    bit  acc = 1'b0;
    int  g = (gap_max > 0) ? int'($urandom_range(gap_max)) : 0;
    s_valid = 1'b0;
    repeat (g) begin
      s_sof = $urandom_range(1);
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = d; s_sof = sof;
    while (!acc) begin
      if (ack_noise) frame_ack = $urandom_range(1);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      waited++;
      if (!acc && waited > 2000) begin
        n_chk++; n_fail++;
        $display("FAIL push_timeout: got no accept expected accept within 2000 cycles");
        break;
      end
    end
    s_valid = 1'b0; s_sof = 1'b0; frame_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; frame_ack = 1'b0;

    // 1: reset
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pixels_zero", 32'(pixels == '0), 32'd1);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("rel_s_ready", 32'(s_ready), 32'd1);
    check("rel_pix_count", 32'(pix_count), 32'd0);
    @(posedge clk); #1;

    // 2: full frame, no gaps
    for (int k = 0; k < NPIX; k++) push(8'(k), k == 0, 0, 1'b0);
    check("t2_frame_valid", 32'(frame_valid), 32'd1);
    check("t2_s_ready", 32'(s_ready), 32'd0);
    check("t2_byte0", 32'(pixels[6271:6264]), 32'h00);
    check("t2_byte300", 32'(pixels[8*(783-300) +: 8]), 32'h2C);
    check("t2_byte783", 32'(pixels[7:0]), 32'h0F);

    // 3: backpressure then ack
    s_valid = 1'b1; s_data = 8'h55;
    repeat (50) @(posedge clk);
    #1;
    check("t3_held_count", 32'(pix_count), 32'd784);
    check("t3_held_byte5", 32'(pixels[8*(783-5) +: 8]), 32'h05);
    s_valid = 1'b0; frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    check("t3_ack_fv", 32'(frame_valid), 32'd0);
    check("t3_ack_ready", 32'(s_ready), 32'd1);
    check("t3_ack_count", 32'(pix_count), 32'd0);

    // 4: early SOF
    for (int k = 0; k < 100; k++) push(8'($urandom), k == 0, 0, 1'b0);
    push(8'hAA, 1'b1, 0, 1'b0);
    check("t4_sof_err", 32'(sof_err), 32'd1);
    check("t4_count", 32'(pix_count), 32'd1);
    check("t4_byte0", 32'(pixels[6271:6264]), 32'hAA);
    for (int k = 1; k < NPIX; k++) push(8'($urandom), 1'b0, 0, 1'b0);
    check("t4_fv", 32'(frame_valid), 32'd1);
    check("t4_sof_pulses", 32'(sof_cnt), 32'd1);
    frame_ack = 1'b1; @(posedge clk); #1; frame_ack = 1'b0;

    // 5: gaps, ack noise and an en=0 window
    for (int k = 0; k < 300; k++) push(8'($urandom), k == 0, 2, 1'b1);
    en = 1'b0; s_valid = 1'b1; s_data = 8'h77; s_sof = 1'b1; frame_ack = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t5_frozen_count", 32'(pix_count), 32'd300);
    check("t5_en0_ready", 32'(s_ready), 32'd0);
    en = 1'b1; s_valid = 1'b0; s_sof = 1'b0; frame_ack = 1'b0;
    for (int k = 300; k < NPIX; k++) push(8'($urandom), 1'b0, 2, 1'b1);
    check("t5_fv", 32'(frame_valid), 32'd1);
    frame_ack = 1'b1; @(posedge clk); #1; frame_ack = 1'b0;

    // 6: resync in IDLE, then reset mid-frame
    for (int k = 0; k < 5; k++) push(8'hEE, 1'b0, 1, 1'b0);
    check("t6_discard_count", 32'(pix_count), 32'd0);
    for (int k = 0; k < 400; k++) push(8'($urandom), k == 0, 0, 1'b0);
    check("t6_count400", 32'(pix_count), 32'd400);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_rst_pixels", 32'(pixels == '0), 32'd1);
    check("t6_rst_count", 32'(pix_count), 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_rel_ready", 32'(s_ready), 32'd1);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1);
  end

endmodule
